// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button front-end and 10 ms prescaler for the stopwatch digit chain.
// Two raw buttons are synchronized, optionally debounced, and edge-detected into one-cycle
// press pulses. The pulses drive a four-state run/pause/lap/clear sequencer. The prescaler
// count sec_count runs only while running.
// Optional feature: define STOPWATCH_DEBOUNCE_EN to insert a per-button debounce counter
// of DEBOUNCE_CYCLES stable cycles between the synchronizer and the edge detector.
module stopwatch_ctrl #(
   parameter int TICK_DIV        = 500000,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_start_stop,
   input  logic        btn_lap_reset,
   output logic [18:0] sec_count,
   output logic        tick,
   output logic        stop,
   output logic        running,
   output logic        lap_hold,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_LAP   = 2'd3
   } state_t;

   // Terminal prescaler value, held at the full 19-bit width for every comparison.
   localparam logic [18:0] TICK_MAX = 19'(TICK_DIV - 1);

   // Bit 0 carries start_stop, bit 1 carries lap_reset throughout the input path.
   logic [1:0]  meta_q, meta_d;
   logic [1:0]  sync_q, sync_d;
   logic [1:0]  lvl;
   logic [1:0]  prev_q, prev_d;
   logic [1:0]  press;
   logic        press_ss;
   logic        press_lr;
   state_t      state_q, state_d;
   logic [18:0] count_q, count_d;

   // Two-flop synchronizer inputs for both raw buttons.
   always_comb begin
      meta_d = {btn_lap_reset, btn_start_stop};
      sync_d = meta_q;
   end

   // Synchronizer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

`ifdef STOPWATCH_DEBOUNCE_EN
   localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]            acc_q, acc_d;
   logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;

   // Accept a new level only after it has differed from the accepted one for
   // DEBOUNCE_CYCLES consecutive cycles; any return to the accepted level restarts the count.
   always_comb begin
      acc_d    = acc_q;
      db_cnt_d = '0;
      for (int i = 0; i < 2; i++) begin
         if (sync_q[i] != acc_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               acc_d[i] = sync_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
         end
      end
   end

   // Debounce registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q    <= '0;
         db_cnt_q <= '0;
      end else begin
         acc_q    <= acc_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   assign lvl = acc_q;
`else
   // Debounce compiled out: the edge detector watches the synchronizer output directly.
   if (DEBOUNCE_CYCLES >= 0) begin : g_no_debounce
      assign lvl = sync_q;
   end
`endif

   // Rising-edge detection on the accepted level gives one pulse per press, none while held.
   always_comb begin
      prev_d   = lvl;
      press    = lvl & ~prev_q;
      press_ss = press[0];
      press_lr = press[1];
   end

   // Edge-detector history register.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= '0;
      end else begin
         prev_q <= prev_d;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; start_stop wins a same-cycle collision and lap_reset is dropped.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (press_ss) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (press_ss)      state_d = ST_PAUSE;
            else if (press_lr) state_d = ST_LAP;
         end
         ST_LAP: begin
            if (press_ss)      state_d = ST_PAUSE;
            else if (press_lr) state_d = ST_RUN;
         end
         ST_PAUSE: begin
            if (press_ss)      state_d = ST_RUN;
            else if (press_lr) state_d = ST_IDLE;
         end
      endcase
   end

   // Prescaler next value, chosen from the current state. A pause can never leave the count
   // parked on its terminal value, or the digit counters would advance every cycle.
   always_comb begin
      count_d = count_q;
      case (state_q)
         ST_IDLE:  count_d = '0;
         ST_RUN,
         ST_LAP:   count_d = (count_q == TICK_MAX) ? '0 : count_q + 19'd1;
         ST_PAUSE: count_d = (count_q == TICK_MAX) ? '0 : count_q;
      endcase
   end

   // Prescaler register.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Output decode from registered state and count.
   always_comb begin
      state     = state_q;
      sec_count = count_q;
      tick      = (count_q == TICK_MAX);
      stop      = (state_q == ST_IDLE);
      running   = (state_q == ST_RUN) || (state_q == ST_LAP);
      lap_hold  = (state_q == ST_LAP);
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=10, DEBOUNCE_CYCLES=4.
// A behavioural model built from button sample history drives a per-cycle compare.
// Directed scenarios add literal expectations, and a randomized phase follows.
module tb_stopwatch_ctrl;

   localparam int TD = 10;
   localparam int DB = 4;
`ifdef STOPWATCH_DEBOUNCE_EN
   localparam int LAT = 2 + DB;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        ss;
   logic        lr;
   logic [18:0] sec_count;
   logic        tick;
   logic        stop;
   logic        running;
   logic        lap_hold;
   logic [1:0]  state;

   int checks   = 0;
   int failures = 0;

   stopwatch_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
      .clk            (clk),
      .reset          (reset),
      .btn_start_stop (ss),
      .btn_lap_reset  (lr),
      .sec_count      (sec_count),
      .tick           (tick),
      .stop           (stop),
      .running        (running),
      .lap_hold       (lap_hold),
      .state          (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // h_x[k] is the button level sampled k edges ago (index 0 = this edge); reset clears history.
   bit h_ss[16];
   bit h_lr[16];
   bit acc_ss, acc_lr, accp_ss, accp_lr;
   int m_state = 0;
   int m_cnt   = 0;
   int ecount  = 0;

   function automatic int fsm_next(input int s, input bit pss, input bit plr);
      case (s)
         0:       return pss ? 1 : 0;
         1:       return pss ? 2 : (plr ? 3 : 1);
         3:       return pss ? 2 : (plr ? 1 : 3);
         default: return pss ? 1 : (plr ? 0 : 2);
      endcase
   endfunction

   // Accepted level flips when the last DB synchronized samples all disagree with it.
   function automatic bit settle(input bit h[16], input bit acc);
      bit all_diff = 1'b1;
      for (int k = 2; k <= DB + 1; k++) if (h[k] == acc) all_diff = 1'b0;
      return all_diff ? ~acc : acc;
   endfunction

   always @(posedge clk) begin
      bit pss, plr;
      ecount++;
      if (reset) begin
         for (int k = 0; k < 16; k++) begin
            h_ss[k] = 1'b0;
            h_lr[k] = 1'b0;
         end
         acc_ss = 0; acc_lr = 0; accp_ss = 0; accp_lr = 0;
         m_state = 0;
         m_cnt   = 0;
      end else begin
         for (int k = 15; k > 0; k--) begin
            h_ss[k] = h_ss[k-1];
            h_lr[k] = h_lr[k-1];
         end
         h_ss[0] = ss;
         h_lr[0] = lr;
`ifdef STOPWATCH_DEBOUNCE_EN
         pss = acc_ss & ~accp_ss;
         plr = acc_lr & ~accp_lr;
         accp_ss = acc_ss;
         accp_lr = acc_lr;
         acc_ss  = settle(h_ss, acc_ss);
         acc_lr  = settle(h_lr, acc_lr);
`else
         pss = h_ss[2] & ~h_ss[3];
         plr = h_lr[2] & ~h_lr[3];
`endif
         case (m_state)
            0:       m_cnt = 0;
            2:       if (m_cnt == TD - 1) m_cnt = 0;
            default: m_cnt = (m_cnt + 1) % TD;
         endcase
         m_state = fsm_next(m_state, pss, plr);
      end
   end

   // ---------------- per-cycle compare ----------------
   bit cmp_en    = 1'b0;
   bit counting  = 1'b0;
   int trans     = 0;
   int last_chg  = 0;
   int prev_seen = 0;

   always @(negedge clk) begin
      if (cmp_en) begin
         check("state",     int'(state),     m_state);
         check("sec_count", int'(sec_count), m_cnt);
         check("tick",      int'(tick),      (m_cnt == TD - 1) ? 1 : 0);
         check("stop",      int'(stop),      (m_state == 0) ? 1 : 0);
         check("running",   int'(running),   (m_state == 1 || m_state == 3) ? 1 : 0);
         check("lap_hold",  int'(lap_hold),  (m_state == 3) ? 1 : 0);
      end
      if (counting && int'(state) != prev_seen) begin
         trans++;
         last_chg = ecount;
      end
      prev_seen = int'(state);
   end

   task automatic press(input bit s, input bit l);
      ss = s;
      lr = l;
      repeat (8) @(negedge clk);
      ss = 1'b0;
      lr = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int ntick;
      int s_edge;
      bit found;
      int rs_left;
      int rl_left;
      reset = 1'b1;
      ss    = 1'b0;
      lr    = 1'b0;
      cmp_en = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_state",   int'(state),     0);
      check("rst_stop",    int'(stop),      1);
      check("rst_count",   int'(sec_count), 0);
      check("rst_tick",    int'(tick),      0);
      check("rst_running", int'(running),   0);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // Run from IDLE: latency and first prescaler period.
      ss = 1'b1;
      for (int k = 1; k <= LAT + 11; k++) begin
         @(negedge clk);
         if (k == 8) ss = 1'b0;
         if (k == LAT) check("run_pre_state", int'(state), 0);
         if (k == LAT + 1) begin
            check("run_state", int'(state), 1);
            check("run_cnt0",  int'(sec_count), 0);
         end
         if (k == LAT + 2) check("run_cnt1", int'(sec_count), 1);
         if (k == LAT + 10) begin
            check("run_cnt9",  int'(sec_count), 9);
            check("run_tick9", int'(tick), 1);
         end
         if (k == LAT + 11) begin
            check("run_wrap",  int'(sec_count), 0);
            check("run_tick0", int'(tick), 0);
         end
      end
      ntick = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (tick) ntick++;
      end
      check("ticks_per_100", ntick, 10);

      // Pause landing on the terminal count.
      found = 1'b0;
      for (int g = 0; g < 40 && !found; g++) begin
         if (m_state == 1 && m_cnt == 8 - LAT) found = 1'b1;
         else @(negedge clk);
      end
      check("pause_align", int'(found), 1);
      ss = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 8) ss = 1'b0;
         if (k == LAT + 1) begin
            check("pmax_state", int'(state), 2);
            check("pmax_cnt9",  int'(sec_count), 9);
            check("pmax_tick",  int'(tick), 1);
         end
         if (k == LAT + 2) begin
            check("pmax_cnt0",  int'(sec_count), 0);
            check("pmax_tick0", int'(tick), 0);
         end
         if (k == LAT + 5) begin
            check("pmax_hold",  int'(sec_count), 0);
            check("pmax_state2", int'(state), 2);
         end
      end
      repeat (8) @(negedge clk);
      ss = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 8) ss = 1'b0;
         if (k == LAT + 1) begin
            check("resume_state", int'(state), 1);
            check("resume_cnt0",  int'(sec_count), 0);
         end
         if (k == LAT + 2) check("resume_cnt1", int'(sec_count), 1);
      end
      repeat (8) @(negedge clk);

      // Lap, release, pause, clear.
      press(1'b0, 1'b1);
      check("lap_state", int'(state), 3);
      check("lap_hold",  int'(lap_hold), 1);
      check("lap_run",   int'(running), 1);
      press(1'b0, 1'b1);
      check("unlap_state", int'(state), 1);
      check("unlap_hold",  int'(lap_hold), 0);
      press(1'b1, 1'b0);
      check("pause_state", int'(state), 2);
      press(1'b0, 1'b1);
      check("clear_state", int'(state), 0);
      check("clear_stop",  int'(stop), 1);
      check("clear_cnt",   int'(sec_count), 0);

      // Lap press ignored in IDLE; simultaneous presses in RUN.
      press(1'b0, 1'b1);
      check("idle_lap_ignored", int'(state), 0);
      press(1'b1, 1'b0);
      check("sim_pre_run", int'(state), 1);
      press(1'b1, 1'b1);
      check("sim_state", int'(state), 2);
      press(1'b0, 1'b1);
      check("sim_clear", int'(state), 0);

      // Bouncing start_stop followed by a steady hold.
      trans    = 0;
      counting = 1'b1;
      for (int k = 0; k < 20; k++) begin
         ss = ((k / 2) % 2 == 0);
         @(negedge clk);
      end
      ss = 1'b1;
      s_edge = ecount + 1;
      repeat (14) @(negedge clk);
      counting = 1'b0;
      ss = 1'b0;
      repeat (12) @(negedge clk);
`ifdef STOPWATCH_DEBOUNCE_EN
      check("bounce_trans", trans, 1);
      check("bounce_edge",  last_chg, s_edge + 2 + DB);
`else
      check("bounce_trans", trans, 6);
`endif

      // Randomized buttons with occasional reset.
      rs_left = 0;
      rl_left = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (rs_left == 0) begin
            ss = 1'($urandom_range(0, 1));
            rs_left = $urandom_range(1, 12);
         end else rs_left--;
         if (rl_left == 0) begin
            lr = 1'($urandom_range(0, 1));
            rl_left = $urandom_range(1, 12);
         end else rl_left--;
         reset = ($urandom_range(0, 199) == 0);
      end
      reset = 1'b0;
      ss = 1'b0;
      lr = 1'b0;
      repeat (10) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control front-end for the stopwatch digit counter chain. It turns two raw push-buttons into run, pause, lap and clear sequencing. It also generates the 10 ms prescaler count `sec_count` that the counter chain uses to advance its 0.01 s digit. It sits between the board buttons and the digit counters, and drives their `stop` clear input and the display freeze.

## Interface
- `TICK_DIV`, default 500000: prescaler period in clk cycles; 10 ms at 50 MHz. Legal range 2..524288.
- `DEBOUNCE_CYCLES`, default 1000000: number of stable cycles required before a button level is accepted. Only used with `STOPWATCH_DEBOUNCE_EN`.
- `clk`  in  1  single system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btn_start_stop`  in  1  raw asynchronous button, active-high.
- `btn_lap_reset`  in  1  raw asynchronous button, active-high.
- `sec_count`  out  19  prescaler count, range 0..TICK_DIV-1.
- `tick`  out  1  high while `sec_count == TICK_DIV-1`.
- `stop`  out  1  clears the digit counters; high in IDLE.
- `running`  out  1  high in RUN or LAP.
- `lap_hold`  out  1  freezes the display; high in LAP.
- `state`  out  2  IDLE=0, RUN=1, PAUSE=2, LAP=3.

## Operation
- **Input path, per button**
  - 2-flop synchronizer.
  - Optional debounce (see Configuration).
  - Rising-edge detector producing a one-cycle press pulse.
- **State machine**
  - IDLE: start_stop press → RUN. lap_reset press is ignored.
  - RUN: start_stop → PAUSE. lap_reset → LAP.
  - LAP: start_stop → PAUSE, which also releases the freeze. lap_reset → RUN, which releases the freeze.
  - PAUSE: start_stop → RUN. lap_reset → IDLE.
- **Simultaneous presses:** when both pulses occur in the same cycle, start_stop is taken and lap_reset is discarded, not queued.
- **Outputs:** `stop`, `running`, `lap_hold` and `tick` are decoded combinationally from registered state and `sec_count`.
- **Prescaler, when running:** increments by 1 each cycle and wraps from TICK_DIV-1 to 0.
- **Prescaler, in PAUSE:** holds its value. Exception: if it equals TICK_DIV-1, it advances to 0 on the next edge. The count must never rest at TICK_DIV-1, otherwise the digit counters would advance every cycle.
- **Prescaler, in IDLE:** forced to 0.
- **Count/state priority:** the count update uses the current state, not the next state.
- **Width rule:** comparisons use the full 19-bit width. `TICK_DIV-1` is computed as a 19-bit constant.

## Timing
- **Reset values:**
  - State IDLE, so `state`=0, `stop`=1, `running`=0, `lap_hold`=0.
  - `sec_count`=0, `tick`=0.
  - Synchronizer, debounce and edge registers cleared to 0.
- **Reset mid-operation:** reset asserted in any state gives the reset values at the next edge. A button still held after reset is released counts as one press.
- **Press latency without debounce:** button first sampled high at edge N → `state` changes at edge N+2. The `sec_count` increment starts at edge N+3.
- **Press latency with debounce:** `state` changes at edge N+2+DEBOUNCE_CYCLES, provided the input stays high throughout.
- **Tick timing:** `tick` is high for exactly one cycle per prescaler period while running, and never more than one cycle in a row.
- **Press rate:** each press yields exactly one transition. Holding a button produces no repeats.

## Configuration
- Macro `STOPWATCH_DEBOUNCE_EN`.
- **Defined:** a per-button counter requires the synchronized level to differ from the accepted level for DEBOUNCE_CYCLES consecutive cycles before the accepted level changes. Any bounce restarts the counter. The edge detector runs on the accepted level.
- **Undefined:** no debounce logic. The edge detector runs directly on the synchronizer output, and DEBOUNCE_CYCLES is unused.

## Test plan
All scenarios use TICK_DIV=10, DEBOUNCE_CYCLES=4.
- **Reset:** assert reset 3 cycles with buttons low → state=0, stop=1, sec_count=0, tick=0, running=0.
- **Run:** start_stop press from IDLE → state=1 two edges after first sample. sec_count runs 0..9 and wraps. tick is high exactly when sec_count=9, once per 10 cycles.
- **Pause at max:** press start_stop so that the pause lands when sec_count=9 → state=2, sec_count goes 9→0 and then holds at 0, tick high one cycle only. A second press → state=1 and counting resumes from 0.
- **Lap and clear:**
  - RUN, lap_reset → state=3, lap_hold=1, sec_count still counting.
  - lap_reset → state=1, lap_hold=0.
  - start_stop, lap_reset → state=0, stop=1, sec_count=0.
- **Simultaneous press:** both buttons pressed in the same cycle while in RUN → state=2, no LAP entry.
- **Debounce (macro defined):** start_stop toggling every 2 cycles for 20 cycles, then held high → exactly one transition, 6 edges after the stable level is first sampled. With the macro undefined, the same stimulus produces multiple transitions.
